// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-cycle execute sequencer feeding an 8-bit ALU, with a 4x8 register file and CB/EXT writeback
module alu_exec_ctrl #(
  parameter int NREGS = 4,
  parameter int RW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_opcode,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_use_imm,
  input  logic [7:0]    in_imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [7:0]    alu_op,
  input  logic [7:0]    alu_result,
  input  logic          alu_cb,
  input  logic [7:0]    alu_ext,
  output logic          flag_cb,
  output logic [7:0]    ext_reg,
  output logic          done,
  output logic          busy,
  input  logic [RW-1:0] dbg_sel,
  output logic [7:0]    dbg_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_regs [NREGS];
  logic [7:0]      r_a, r_b, r_op, r_ext;
  logic [RW-1:0]   r_rd;
  logic            r_cb;
  logic            w_accept, w_commit;
  logic [3:0]      w_hi;
  logic            w_arith, w_mul, w_logic, w_cmp;
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_commit = (r_state == EXEC);
  assign w_hi     = r_op[7:4];
  assign w_arith  = (w_hi == 4'h1) || (w_hi == 4'h2) || (r_op == 8'h06) || (r_op == 8'h07);
  assign w_mul    = (w_hi == 4'h3);
  assign w_logic  = (r_op >= 8'h01 && r_op <= 8'h05) || (w_hi == 4'h5) || (w_hi == 4'h6);
  assign w_cmp    = (w_hi == 4'h7);
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == WB);
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_op   = r_op;
  assign flag_cb  = r_cb;
  assign ext_reg  = r_ext;
  assign dbg_data = r_regs[dbg_sel];
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: IDLE -> EXEC -> WB -> IDLE, leaving IDLE only on accept
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? EXEC : IDLE;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // operand/opcode latch on accept; held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_rd <= '0;
    end else if (w_accept) begin
      r_a  <= r_regs[in_rs1];
      r_b  <= in_use_imm ? in_imm : r_regs[in_rs2];
      r_op <= in_opcode;
      r_rd <= in_rd;
    end
  end
  // writeback at the closing edge of EXEC, gated by the opcode class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_cb  <= 1'b0;
      r_ext <= '0;
    end else if (w_commit) begin
      if (w_arith || w_mul || w_logic) r_regs[r_rd] <= alu_result;
      if (w_arith || w_cmp)            r_cb         <= alu_cb;
      if (w_mul)                       r_ext        <= alu_ext;
    end
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer that sits directly upstream of the 8-bit ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU operand and opcode inputs from registers.
- Captures the ALU's result, carry/borrow and extension outputs, then writes them back to the register file, the CB flag register and the EXT register.

Parameters:
- NREGS, 4, number of 8-bit general registers; must be a power of 2.
- RW, 2, register index width; equals log2(NREGS).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- in_opcode  in  8  ALU opcode; encoding identical to the ALU's.
- in_rd  in  RW  destination register.
- in_rs1  in  RW  source register for operand A.
- in_rs2  in  RW  source register for operand B.
- in_use_imm  in  1  1 = operand B is in_imm, 0 = operand B is R[in_rs2].
- in_imm  in  8  immediate value.
- alu_a  out  8  ALU operandA, registered.
- alu_b  out  8  ALU operandB, registered.
- alu_op  out  8  ALU opcode, registered.
- alu_result  in  8  ALU result, combinational from alu_*.
- alu_cb  in  1  ALU carry/borrow.
- alu_ext  in  8  ALU extended (MUL high byte).
- flag_cb  out  1  carry/borrow flag register.
- ext_reg  out  8  extension register.
- done  out  1  one-cycle pulse: instruction retired.
- busy  out  1  high in EXEC and WB.
- dbg_sel  in  RW  debug register select.
- dbg_data  out  8  R[dbg_sel], combinational read.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all R[i]=0x00; flag_cb=0; ext_reg=0x00.
  - alu_a=alu_b=alu_op=0x00; done=0; busy=0; in_ready=1 once rst_n deasserts.
- Handshake:
  - in_ready = (state==IDLE). Accept when in_valid & in_ready at a rising edge.
  - Inputs are don't-care when not accepted. in_valid may stay high; the next accept happens on the next IDLE cycle.
- FSM, IDLE -> EXEC -> WB -> IDLE, throughput one instruction per 3 cycles:
  - IDLE: on accept, latch alu_a=R[in_rs1], alu_b=(in_use_imm ? in_imm : R[in_rs2]), alu_op=in_opcode, and rd; go to EXEC.
  - EXEC (1 cycle): ALU output settles. At the closing edge, commit writeback per the class rules below; go to WB.
  - WB (1 cycle): done=1; go to IDLE. done is 0 in every other state.
- Operand reads use register contents as of the accept edge. rd may equal rs1 or rs2.
- alu_a, alu_b and alu_op hold their values after WB until the next accept.
- Writeback classes, decoded from alu_op with the ALU's encoding:
  - ADD 0001xxxx, SUB 0010xxxx, INC 0x06, DEC 0x07: R[rd]=alu_result; flag_cb=alu_cb.
  - MUL 0011xxxx: R[rd]=alu_result; ext_reg=alu_ext; flag_cb unchanged.
  - LSL/LSR/CIR/CIL/ASR 0x01-0x05, AND 0101xxxx, XOR 0110xxxx: R[rd]=alu_result; flags unchanged.
  - CMP 0111xxxx: flag_cb=alu_cb; R[rd] unchanged.
  - All other opcodes (NOP, 0x00, 0x08-0x0F, 01xx not listed, 1xxxxxxx): no writes. done still pulses.
- ext_reg is written only by MUL. flag_cb is written only by ADD/SUB/INC/DEC/CMP.
- dbg_data reflects a writeback starting in the cycle after the commit edge.
- Reset during EXEC or WB: the instruction is aborted with no writeback, done=0, and the block restarts in IDLE.

Test Plan:
- Reset, then ADD rd=0 rs1=0 imm=0xF0; then ADD rd=0 rs1=0 imm=0x20 -> R0=0x10, flag_cb=1, done pulses once per instruction, exactly 3 cycles between accepts.
- R1=0x12 (ADD imm), R2=0x34; MUL rd=3 rs1=1 rs2=2 -> R3=0xA8, ext_reg=0x03, flag_cb unchanged from its prior value.
- R1=0x05; CMP rs1=1 imm=0x07 -> flag_cb=1, R[rd] unchanged; then CMP imm=0x05 -> flag_cb=0.
- in_valid held high with 4 back-to-back INC rd=rs1=0 starting at R0=0xFE -> in_ready low in EXEC/WB; R0 sequence 0xFF, 0x00 (flag_cb=1), 0x01, 0x02; 4 done pulses.
- Opcode 0x00 and 0x80 with rd=0 -> no register, flag or ext change; done pulses; alu_op shows the opcode.
- Assert rst_n=0 during EXEC of ADD rd=2 -> R2=0x00, no done pulse, state IDLE, in_ready=1 after release.
